// File: rtl/rom_stream_pkg.sv
// Shared types and width helpers for the ROM stream reader.
package rom_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int unsigned addr_w(input int unsigned size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

    // One extra bit so a full-table length (LEN == SIZE) is representable.
    function automatic int unsigned len_w(input int unsigned size);
        return $clog2(size) + 1;
    endfunction

endpackage

// File: rtl/rom_stream_reader_if.sv
// Valid/ready word stream with start/end-of-message markers.
interface rom_stream_reader_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;
    logic             som;
    logic             eom;

    modport master (output data, output valid, output som, output eom, input ready);
    modport slave  (input data, input valid, input som, input eom, output ready);
endinterface

// File: rtl/rom_stream_outreg.sv
// Output holding register: data plus SOM/EOM, loads whenever empty or draining.
module rom_stream_outreg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_som,
    input  logic             i_eom,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_som,
    output logic             o_eom,
    output logic             o_load_en
);

    logic [WIDTH+1:0] r_word;
    logic             r_valid;
    logic             w_load_en;

    assign w_load_en = !r_valid || i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_word  <= '0;
            r_valid <= 1'b0;
        end else if (w_load_en) begin
            r_valid <= i_load;
            if (i_load) begin
                r_word <= {i_som, i_eom, i_data};
            end
        end
    end

    assign {o_som, o_eom, o_data} = r_word;
    assign o_valid   = r_valid;
    assign o_load_en = w_load_en;

endmodule

// File: rtl/rom_stream_reader.sv
// Plays LEN consecutive ROM words from BASE onto a valid/ready stream.
// Optional block looping is enabled by defining ROM_STREAM_LOOP_EN (adds i_loop).
module rom_stream_reader
    import rom_stream_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned SIZE  = 256,
    localparam int unsigned AW    = addr_w(SIZE),
    localparam int unsigned LW    = len_w(SIZE)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic [AW-1:0]               i_base,
    input  logic [LW-1:0]               i_len,
    input  logic                        i_stop,
`ifdef ROM_STREAM_LOOP_EN
    input  logic                        i_loop,
`endif
    output logic                        o_busy,
    output logic                        o_done,
    output logic [AW-1:0]               o_rom_addr,
    input  logic [WIDTH-1:0]            i_rom_do,
    rom_stream_reader_if.master         o_stream
);

    state_t           r_state;
    logic [AW-1:0]    r_addr;
    logic [AW-1:0]    r_base;
    logic [LW-1:0]    r_rem;
    logic [LW-1:0]    r_len;
    logic             r_first;
    logic             r_loop;
    logic             r_done;

    logic             w_loop_in;
    logic             w_load_en;
    logic             w_load;
    logic             w_last;
    logic             w_valid;
    logic             w_ready;
    logic [WIDTH-1:0] w_data;
    logic             w_som;
    logic             w_eom;

`ifdef ROM_STREAM_LOOP_EN
    assign w_loop_in = i_loop;
`else
    assign w_loop_in = 1'b0;
`endif

    assign w_ready = o_stream.ready;
    assign w_last  = (r_rem == LW'(1));
    assign w_load  = (r_state == RUN) && !i_stop && w_load_en;

    rom_stream_outreg #(
        .WIDTH (WIDTH)
    ) u_outreg (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (w_load),
        .i_data    (i_rom_do),
        .i_som     (r_first),
        .i_eom     (w_last && !r_loop),
        .i_ready   (w_ready),
        .o_data    (w_data),
        .o_valid   (w_valid),
        .o_som     (w_som),
        .o_eom     (w_eom),
        .o_load_en (w_load_en)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_base  <= '0;
            r_rem   <= '0;
            r_len   <= '0;
            r_first <= 1'b0;
            r_loop  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start && (i_len != '0)) begin
                        r_addr  <= i_base;
                        r_base  <= i_base;
                        r_rem   <= i_len;
                        r_len   <= i_len;
                        r_first <= 1'b1;
                        r_loop  <= w_loop_in;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (i_stop) begin
                        r_state <= DRAIN;
                    end else if (w_load_en) begin
                        // Looping rewinds to the captured block with no gap cycle.
                        if (w_last && r_loop) begin
                            r_addr  <= r_base;
                            r_rem   <= r_len;
                            r_first <= 1'b1;
                        end else begin
                            r_addr  <= r_addr + AW'(1);
                            r_rem   <= r_rem - LW'(1);
                            r_first <= 1'b0;
                            if (w_last) begin
                                r_state <= DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (!w_valid || w_ready) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy         = (r_state != IDLE);
    assign o_done         = r_done;
    assign o_rom_addr     = r_addr;
    assign o_stream.data  = w_data;
    assign o_stream.valid = w_valid;
    assign o_stream.som   = w_som;
    assign o_stream.eom   = w_eom;

endmodule
